controlador_texto: RTL
======================

Name: controlador_texto

Overview:
- Text-overlay renderer that sequences the 8x16 font ROM (3-bit character code × 4-bit glyph row → 8-bit row pattern) for the VGA display path.
- Holds a small writable character buffer and maps live pixel coordinates onto a fixed text window.
- Drives the ROM address, selects the pixel bit, applies a blinking cursor and emits colour.
- Sits between the VGA sync generator and the RGB output mux.

Parameters:
X0, 64, left pixel column of the text window
Y0, 32, top pixel row of the text window
N_CHARS, 8, characters in the window (1..16)
BLINK_FRAMES, 30, frame_tick pulses per cursor blink half-period
FG_RGB, 12'hFFF, glyph foreground colour
BG_RGB, 12'h008, window background colour

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-high reset
pixel_x  in  10  current pixel column from VGA sync
pixel_y  in  10  current pixel row from VGA sync
video_on  in  1  visible-area flag from VGA sync
frame_tick  in  1  one-cycle pulse per frame
wr_en  in  1  character buffer write strobe
wr_addr  in  4  buffer entry to write
wr_data  in  3  character code to write
cursor_en  in  1  enable blinking cursor
cursor_pos  in  4  cursor character position
direccion  out  3  font ROM character code
rom  out  4  font ROM glyph row
rom_data  in  8  font ROM row pattern (combinational return)
pixel_on  out  1  glyph pixel lit
en_ventana  out  1  pixel inside text window
rgb  out  12  output colour

Behaviour:
- Clock and reset:
  - Single clock `clk`. `reset` is asynchronous, active-high.
  - On reset: direccion=0, rom=0, pixel_on=0, en_ventana=0, rgb=0, blink counter=0, blink phase=1 (cursor shown).
  - Buffer entry i loads code i+1 for i<6; all other entries load 0 (space).
- Window decode (combinational on inputs):
  - in_win = (X0 ≤ pixel_x < X0+8*N_CHARS) and (Y0 ≤ pixel_y < Y0+16).
  - dx=pixel_x−X0 (10-bit); col=dx[6:3]; bit_sel=dx[2:0]; row=(pixel_y−Y0)[3:0].
- Stage 1, edge after input cycle t:
  - direccion ← buf[col] if in_win, else 0.
  - rom ← row if in_win, else 0.
  - Register in_win, video_on, bit_sel, and cur_hit = cursor_en & blink phase & (col==cursor_pos).
- ROM access: returns rom_data combinationally during stage 1.
- Stage 2, edge t+2:
  - bitv = rom_data[7−bit_sel] XOR cur_hit.
  - pixel_on ← s1_video & s1_in_win & bitv.
  - en_ventana ← s1_video & s1_in_win.
  - rgb ← FG_RGB if pixel_on term is true; BG_RGB if en_ventana term is true; else 0.
  - Total latency: 2 clocks from inputs to pixel_on/en_ventana/rgb. The sync generator delays hsync/vsync by 2 to match.
- Character buffer:
  - Written on the clock edge when wr_en=1.
  - wr_addr ≥ N_CHARS is ignored.
  - Write and read of the same entry in the same cycle: the read returns the old code; the new code is visible from the next cycle.
- Blink:
  - Counter increments on frame_tick.
  - When the counter reaches BLINK_FRAMES−1 and frame_tick=1: counter←0, phase toggles.
  - cursor_pos ≥ N_CHARS never hits.
  - cursor_en=0 suppresses inversion only; the counter keeps running.
- Boundaries:
  - Pixel at x=X0+8*N_CHARS or y=Y0+16 is outside the window.
  - pixel_x<X0 gives negative dx; it is excluded by in_win, not by the dx wrap.
  - video_on=0 forces all outputs low / rgb=0 after the 2-cycle latency.
- Reset mid-frame: pipeline clears immediately (asynchronously); outputs are valid again 2 cycles after reset deasserts.

Test Plan:
1. Reset released; pixel (64,34), video_on=1 → direccion=1, rom=2 after 1 clk. After 2 clk: pixel_on=1, en_ventana=1, rgb=FFF (J row 2 = 8'hFE, bit 7).
2. Pixel (71,34) → after 2 clk: pixel_on=0, en_ventana=1, rgb=008. Pixel (128,34) → en_ventana=0, rgb=000.
3. Write wr_addr=0, wr_data=3, same cycle as read of col 0 → that pixel uses code 1. Next pixel (64,40) → direccion=3, rom=8, pixel_on=1 (M row 8 = 8'hFE).
4. cursor_en=1, cursor_pos=6 (space); pixel (112,40) → pixel_on=1. After 30 frame_tick pulses → pixel_on=0. After 30 more → pixel_on=1.
5. video_on=0 on pixel (64,34) → 2 clk later: pixel_on=0, rgb=000. wr_addr=9 write → buffer unchanged.
6. Assert reset mid-window while pixel_on=1 → outputs 0 immediately, buffer back to default codes, blink phase=1.

Source files
------------

// File: rtl/controlador_texto_if.sv
// Pixel-stream, character-buffer and font-ROM signals of the text overlay.
// slave is the renderer's view; master is the view of whatever drives it.
interface controlador_texto_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [2:0]  wr_data;
  logic        cursor_en;
  logic [3:0]  cursor_pos;
  logic [2:0]  direccion;
  logic [3:0]  rom;
  logic [7:0]  rom_data;
  logic        pixel_on;
  logic        en_ventana;
  logic [11:0] rgb;

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick,
    input  wr_en, wr_addr, wr_data, cursor_en, cursor_pos, rom_data,
    output direccion, rom, pixel_on, en_ventana, rgb
  );

  modport master (
    output pixel_x, pixel_y, video_on, frame_tick,
    output wr_en, wr_addr, wr_data, cursor_en, cursor_pos, rom_data,
    input  direccion, rom, pixel_on, en_ventana, rgb
  );
endinterface

// File: rtl/controlador_texto.sv
// Text-overlay renderer: maps pixels onto a character window, addresses the
// font ROM in stage 1, picks the glyph bit and colour in stage 2.
module controlador_texto #(
  parameter int          X0           = 64,
  parameter int          Y0           = 32,
  parameter int          N_CHARS      = 8,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h008
) (
  input logic clk,
  input logic reset,
  controlador_texto_if.slave bus
);
  localparam logic [9:0] X0_W = 10'(X0);
  localparam logic [9:0] XE_W = 10'(X0 + 8 * N_CHARS);
  localparam logic [9:0] Y0_W = 10'(Y0);
  localparam logic [9:0] YE_W = 10'(Y0 + 16);
  localparam logic [4:0] N_W  = 5'(N_CHARS);
  localparam int         CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [2:0]    buf_q [16];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  logic [2:0]  dir_q, dir_d;
  logic [3:0]  row_q, row_d;
  logic        s1_win_q, s1_vid_q, s1_hit_q, s1_hit_d;
  logic [2:0]  s1_bit_q;
  logic        pix_q, pix_d, win_q, win_d;
  logic [11:0] rgb_q, rgb_d;

  logic       in_win;
  logic [6:0] dx;
  logic [3:0] dy;
  logic [3:0] col;
  logic       bitv;

  // Only the low bits of the offsets matter; pixels left of or above the
  // window are rejected by in_win, never by the subtraction wrap.
  always_comb begin
    in_win = (bus.pixel_x >= X0_W) && (bus.pixel_x < XE_W) &&
             (bus.pixel_y >= Y0_W) && (bus.pixel_y < YE_W);
    dx  = bus.pixel_x[6:0] - X0_W[6:0];
    dy  = bus.pixel_y[3:0] - Y0_W[3:0];
    col = dx[6:3];
  end

  always_comb begin
    dir_d    = in_win ? buf_q[col] : 3'd0;
    row_d    = in_win ? dy : 4'd0;
    s1_hit_d = bus.cursor_en & phase_q & (col == bus.cursor_pos) &
               ({1'b0, bus.cursor_pos} < N_W);
    bitv     = bus.rom_data[3'd7 - s1_bit_q] ^ s1_hit_q;
    pix_d    = s1_vid_q & s1_win_q & bitv;
    win_d    = s1_vid_q & s1_win_q;
    rgb_d    = 12'h000;
    if (pix_d)      rgb_d = FG_RGB;
    else if (win_d) rgb_d = BG_RGB;
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (bus.frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        buf_q[i] <= (i < 6 && i < N_CHARS) ? 3'(i + 1) : 3'd0;
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < N_W)) begin
      buf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      dir_q    <= 3'd0;
      row_q    <= 4'd0;
      s1_win_q <= 1'b0;
      s1_vid_q <= 1'b0;
      s1_hit_q <= 1'b0;
      s1_bit_q <= 3'd0;
      pix_q    <= 1'b0;
      win_q    <= 1'b0;
      rgb_q    <= 12'h000;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      row_q    <= row_d;
      s1_win_q <= in_win;
      s1_vid_q <= bus.video_on;
      s1_hit_q <= s1_hit_d;
      s1_bit_q <= dx[2:0];
      pix_q    <= pix_d;
      win_q    <= win_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.direccion  = dir_q;
  assign bus.rom        = row_q;
  assign bus.pixel_on   = pix_q;
  assign bus.en_ventana = win_q;
  assign bus.rgb        = rgb_q;
endmodule
